// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states and multiplier length.
package exec_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_WB      = 2'd2
  } exec_state_e;

  localparam int unsigned MUL_CYCLES = 8;

endpackage

// File: rtl/shift_add_multiplier.sv
// Unsigned shift-add multiplier: operands latched on start, one partial product per cycle.
module shift_add_multiplier
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic [DATA_W-1:0]     multiplier,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int unsigned IdxW = $clog2(DATA_W);

  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   mcand_q;
  logic [DATA_W-1:0]   mplr_q;
  logic [2*DATA_W-1:0] acc_q;
  logic                busy_q;
  logic                last;

  assign last    = busy_q && (cnt_q == 4'(MUL_CYCLES - 1));
  assign busy    = busy_q;
  assign done    = last;
  assign product = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start && !busy_q) begin
      cnt_q   <= '0;
      mcand_q <= multiplicand;
      mplr_q  <= multiplier;
      acc_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (mplr_q[cnt_q[IdxW-1:0]]) begin
        acc_q <= acc_q + ({{DATA_W{1'b0}}, mcand_q} << cnt_q);
      end
      if (last) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: ALU, shift-add MUL and dual-port write-back into the register bank.
module execute_unit
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] dst_a,
  input  logic [ADDR_W-1:0] dst_b,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic              rb_rw,
  output logic [ADDR_W-1:0] rb_add1i,
  output logic [ADDR_W-1:0] rb_add2i,
  output logic [DATA_W-1:0] rb_ip1,
  output logic [DATA_W-1:0] rb_ip2,
  output logic              done,
  output logic              flag_z,
  output logic              flag_c
);

  exec_state_e         state_q, state_d;
  logic [2:0]          opc_q;
  logic [ADDR_W-1:0]   dst_a_q, dst_b_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                flag_z_q, flag_c_q;

  logic                accept;
  logic                wb_active;
  logic                mul_busy, mul_done;
  logic [2*DATA_W-1:0] mul_product;

  logic [DATA_W-1:0]   res, res_hi;
  logic                c_new, z_new;

  assign instr_ready = (state_q == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  // A reset landing on the write-back cycle must keep the bank in read mode.
  assign wb_active   = (state_q == ST_WB) && !rst;

  shift_add_multiplier #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (accept && (opcode == OP_MUL)),
    .multiplicand (op1),
    .multiplier   (op2),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = (opcode == OP_MUL) ? ST_MUL_RUN : ST_WB;
      ST_MUL_RUN: if (mul_done || !mul_busy) state_d = ST_WB;
      ST_WB:      state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opc_q    <= '0;
      dst_a_q  <= '0;
      dst_b_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opc_q   <= opcode;
        dst_a_q <= dst_a;
        dst_b_q <= dst_b;
        a_q     <= op1;
        b_q     <= op2;
      end
      if (wb_active) begin
        flag_z_q <= z_new;
        flag_c_q <= c_new;
      end
    end
  end

  always_comb begin
    res    = '0;
    res_hi = '0;
    c_new  = 1'b0;
    case (opc_q)
      OP_ADD: {c_new, res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        res   = a_q - b_q;
        c_new = (a_q < b_q);
      end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_SHL: begin
        res   = {a_q[DATA_W-2:0], 1'b0};
        c_new = a_q[DATA_W-1];
      end
      OP_MUL: begin
        res    = mul_product[DATA_W-1:0];
        res_hi = mul_product[2*DATA_W-1:DATA_W];
        c_new  = |res_hi;
      end
      default: res = a_q;
    endcase
    z_new = (opc_q == OP_MUL) ? (mul_product == '0) : (res == '0);
  end

  always_comb begin
    rb_rw    = 1'b1;
    rb_add1i = '0;
    rb_add2i = '0;
    rb_ip1   = '0;
    rb_ip2   = '0;
    done     = 1'b0;
    if (wb_active) begin
      rb_rw    = 1'b0;
      done     = 1'b1;
      rb_add1i = dst_a_q;
      rb_ip1   = res;
      if (opc_q == OP_MUL) begin
        rb_add2i = dst_b_q;
        rb_ip2   = res_hi;
      end else begin
        rb_add2i = dst_a_q;
        rb_ip2   = res;
      end
    end
  end

  assign flag_z = wb_active ? z_new : flag_z_q;
  assign flag_c = wb_active ? c_new : flag_c_q;

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: cycle-level reference model plus directed and random stimulus.
module tb_execute_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] opcode;
  logic [1:0] dst_a, dst_b;
  logic [7:0] op1, op2;
  logic       rb_rw;
  logic [1:0] rb_add1i, rb_add2i;
  logic [7:0] rb_ip1, rb_ip2;
  logic       done, flag_z, flag_c;

  execute_unit #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .dst_a       (dst_a),
    .dst_b       (dst_b),
    .op1         (op1),
    .op2         (op2),
    .rb_rw       (rb_rw),
    .rb_add1i    (rb_add1i),
    .rb_add2i    (rb_add2i),
    .rb_ip1      (rb_ip1),
    .rb_ip2      (rb_ip2),
    .done        (done),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference semantics of one instruction, straight from the opcode table.
  task automatic calc(input int op, input int a, input int b,
                      output int lo, output int hi, output bit z, output bit c);
    int s;
    lo = 0; hi = 0; c = 0;
    case (op)
      0: begin s = a + b; lo = s % 256; c = (s > 255); end
      1: begin lo = (a - b + 256) % 256; c = (a < b); end
      2: lo = a & b;
      3: lo = a | b;
      4: lo = a ^ b;
      5: begin lo = (a * 2) % 256; c = (a >= 128); end
      6: begin s = a * b; lo = s % 256; hi = s / 256; c = (s >= 256); end
      default: lo = a;
    endcase
    z = (op == 6) ? (lo == 0 && hi == 0) : (lo == 0);
  endtask

  // Model: cycles remaining until write-back (0 = idle), pending instruction, flags.
  bit   chk_en = 0;
  int   m_wait = 0;
  int   m_op, m_a, m_b, m_da, m_db;
  bit   m_z = 0, m_c = 0;
  logic [7:0] bank [4];
  int   cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, acc_cnt = 0, acc_cyc = 0;

  always @(negedge clk) begin
    int  r_lo, r_hi;
    bit  r_z, r_c;
    bit  e_ready, e_rw, e_done, e_z, e_c;
    int  e_a1, e_a2, e_ip1, e_ip2;
    if (chk_en) begin
      cyc++;
      e_ready = (m_wait == 0);
      e_rw = 1; e_done = 0; e_a1 = 0; e_a2 = 0; e_ip1 = 0; e_ip2 = 0;
      e_z = m_z; e_c = m_c;
      r_lo = 0; r_hi = 0; r_z = 0; r_c = 0;
      if (m_wait == 1 && !rst) begin
        calc(m_op, m_a, m_b, r_lo, r_hi, r_z, r_c);
        e_rw = 0; e_done = 1; e_a1 = m_da; e_ip1 = r_lo;
        e_a2  = (m_op == 6) ? m_db : m_da;
        e_ip2 = (m_op == 6) ? r_hi : r_lo;
        e_z = r_z; e_c = r_c;
      end
      check("instr_ready", 32'(instr_ready), 32'(e_ready));
      check("rb_rw",       32'(rb_rw),       32'(e_rw));
      check("done",        32'(done),        32'(e_done));
      check("rb_add1i",    32'(rb_add1i),    e_a1);
      check("rb_add2i",    32'(rb_add2i),    e_a2);
      check("rb_ip1",      32'(rb_ip1),      e_ip1);
      check("rb_ip2",      32'(rb_ip2),      e_ip2);
      check("flag_z",      32'(flag_z),      32'(e_z));
      check("flag_c",      32'(flag_c),      32'(e_c));
      // Bank applies port 1 then port 2.
      if (rb_rw === 1'b0) begin
        bank[rb_add1i] = rb_ip1;
        bank[rb_add2i] = rb_ip2;
        wr_cnt++;
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (instr_valid && instr_ready === 1'b1 && !rst) begin acc_cnt++; acc_cyc = cyc; end
      if (rst) begin
        m_wait = 0; m_z = 0; m_c = 0;
      end else if (m_wait == 0) begin
        if (instr_valid) begin
          m_op = opcode; m_a = op1; m_b = op2; m_da = dst_a; m_db = dst_b;
          m_wait = (opcode == 3'b110) ? 9 : 1;
        end
      end else begin
        if (m_wait == 1) begin m_z = r_z; m_c = r_c; end
        m_wait--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input int op, input int a, input int b, input int da, input int db);
    int guard = 0;
    while (instr_ready !== 1'b1 && guard < 40) begin tick(1); guard++; end
    if (guard >= 40) check("issue_ready_timeout", 32'(instr_ready), 1);
    instr_valid = 1; opcode = 3'(op); op1 = 8'(a); op2 = 8'(b); dst_a = 2'(da); dst_b = 2'(db);
    tick(1);
    instr_valid = 0;
  endtask

  // Leaves the caller #1 after the negedge of the done cycle.
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (done === 1'b1) seen = 1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    int w0, a0, d0;
    rst = 1; instr_valid = 0; opcode = 0; dst_a = 0; dst_b = 0; op1 = 0; op2 = 0;
    for (int i = 0; i < 4; i++) bank[i] = 8'h00;
    @(posedge clk); #1;
    chk_en = 1;
    tick(1);
    rst = 0;

    w0 = wr_cnt;
    tick(20);
    check("idle_ready", 32'(instr_ready), 1);
    check("idle_rw", 32'(rb_rw), 1);
    check("idle_no_write", wr_cnt - w0, 0);
    check("idle_flags", {30'd0, flag_z, flag_c}, 0);

    issue(0, 8'hF0, 8'h20, 2, 0); wait_done();
    check("add_addr", {28'd0, rb_add1i, rb_add2i}, 32'hA);
    check("add_data", {16'd0, rb_ip1, rb_ip2}, 32'h1010);
    check("add_flags_zc", {30'd0, flag_z, flag_c}, 32'h1);
    @(posedge clk); #1;

    issue(1, 8'h55, 8'h55, 1, 0); wait_done();
    check("sub_eq_res", 32'(rb_ip1), 0);
    check("sub_eq_flags_zc", {30'd0, flag_z, flag_c}, 32'h2);
    @(posedge clk); #1;
    issue(1, 8'h01, 8'h02, 1, 0); wait_done();
    check("sub_borrow_res", 32'(rb_ip1), 32'hFF);
    check("sub_borrow_c", 32'(flag_c), 1);
    @(posedge clk); #1;

    issue(6, 8'hFF, 8'hFF, 1, 3); wait_done();
    check("mul_latency", done_cyc - acc_cyc, 9);
    check("mul_lo", {24'd0, rb_ip1}, 32'h01);
    check("mul_hi", {24'd0, rb_ip2}, 32'hFE);
    check("mul_c", 32'(flag_c), 1);
    check("bank_r1", 32'(bank[1]), 32'h01);
    check("bank_r3", 32'(bank[3]), 32'hFE);
    @(posedge clk); #1;

    issue(6, 8'h10, 8'h10, 2, 2); wait_done();
    check("mul_same_dst_bank", 32'(bank[2]), 32'h01);
    @(posedge clk); #1;

    // Hold valid across a whole MUL: second accept only right after write-back.
    while (instr_ready !== 1'b1) tick(1);
    a0 = acc_cnt; d0 = done_cnt;
    instr_valid = 1; opcode = 3'b110; op1 = 8'd3; op2 = 8'd5; dst_a = 0; dst_b = 1;
    tick(19);
    instr_valid = 0;
    check("hold_accepts", acc_cnt - a0, 2);
    check("hold_dones", done_cnt - d0, 1);
    check("hold_reaccept_gap", acc_cyc - done_cyc, 1);
    wait_done();
    @(posedge clk); #1;

    issue(0, 8'hFF, 8'h01, 0, 0); wait_done();
    check("add_wrap_flags_zc", {30'd0, flag_z, flag_c}, 32'h3);
    @(posedge clk); #1;

    issue(6, 8'h0F, 8'h0F, 0, 1);
    tick(3);
    w0 = wr_cnt;
    rst = 1; tick(1); rst = 0;
    check("rst_ready", 32'(instr_ready), 1);
    check("rst_rw", 32'(rb_rw), 1);
    check("rst_flags", {30'd0, flag_z, flag_c}, 0);
    tick(12);
    check("rst_no_write", wr_cnt - w0, 0);
    issue(7, 8'h00, 8'h33, 1, 0); wait_done();
    check("mov_zero_z", 32'(flag_z), 1);
    @(posedge clk); #1;
    check("flag_z_hold", 32'(flag_z), 1);

    for (int i = 0; i < 1500; i++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      opcode = 3'($urandom_range(0, 7));
      op1 = 8'($urandom); op2 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) op2 = op1;
      dst_a = 2'($urandom); dst_b = 2'($urandom);
      tick(1);
    end
    instr_valid = 0;
    tick(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
